cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_if.sv | 36 +++
 rtl/cdb_arbiter.sv | 133 +++++++++++++
 tb/tb_cdb_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Result buses feeding the CDB arbiter and the broadcast bus it drives.
// master = result producers / CDB consumers, slave = the arbiter.
interface cdb_arbiter_if #(
  parameter int ROB_ID_W = 4
);
  logic                alu_en;
  logic [ROB_ID_W-1:0] alu_rob_id;
  logic [31:0]         alu_val;
  logic [31:0]         alu_pc;
  logic                alu_br;
  logic                lsb_en;
  logic [ROB_ID_W-1:0] lsb_rob_id;
  logic [31:0]         lsb_val;
  logic                alu_full;
  logic                lsb_full;
  logic                cdb_en;
  logic [ROB_ID_W-1:0] cdb_rob_id;
  logic [31:0]         cdb_val;
  logic [31:0]         cdb_pc;
  logic                cdb_br;
  logic                cdb_src;

  modport master (
    output alu_en, alu_rob_id, alu_val, alu_pc, alu_br,
    output lsb_en, lsb_rob_id, lsb_val,
    input  alu_full, lsb_full,
    input  cdb_en, cdb_rob_id, cdb_val, cdb_pc, cdb_br, cdb_src
  );

  modport slave (
    input  alu_en, alu_rob_id, alu_val, alu_pc, alu_br,
    input  lsb_en, lsb_rob_id, lsb_val,
    output alu_full, lsb_full,
    output cdb_en, cdb_rob_id, cdb_val, cdb_pc, cdb_br, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Two-source common data bus arbiter: per-source FIFOs (ALU=0, LSB=1),
// round-robin grant, one registered broadcast per cycle.
module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8,
  parameter int PW    = 1,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          rd,
  input  logic          clr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  head,
  output logic [CW-1:0] cnt
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rp, wp;

  // Power-of-2 depth lets the pointers wrap on natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else if (clr) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      cnt <= cnt + CW'(wr) - CW'(rd);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= wdata;
  end

  assign head = mem[rp];
endmodule

module cdb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int ROB_ID_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  cdb_arbiter_if.slave bus,
  output logic        ovf_err,
  output logic [15:0] conflict_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int W  = ROB_ID_W + 65;

  logic [1:0]         en_in, full, nonempty, wr, rd, gnt;
  logic [1:0][W-1:0]  wdata, head;
  logic [1:0][CW-1:0] cnt;
  logic               last_src;

  logic                cdb_en, cdb_br, cdb_src;
  logic [ROB_ID_W-1:0] cdb_rob_id;
  logic [31:0]         cdb_val, cdb_pc;

  assign en_in    = {bus.lsb_en, bus.alu_en};
  assign wdata[0] = {bus.alu_rob_id, bus.alu_val, bus.alu_pc, bus.alu_br};
  assign wdata[1] = {bus.lsb_rob_id, bus.lsb_val, 32'h0, 1'b0};

  for (genvar g = 0; g < 2; g++) begin : g_src
    assign full[g]     = (cnt[g] == CW'(FIFO_DEPTH));
    assign nonempty[g] = (cnt[g] != '0);
    // Full is judged on the registered count, so a same-edge pop never frees room.
    assign wr[g]       = rdy & ~clear & en_in[g] & ~full[g];
    assign rd[g]       = rdy & ~clear & gnt[g];

    cdb_fifo #(.DEPTH(FIFO_DEPTH), .W(W), .PW(PW), .CW(CW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr[g]),
      .rd    (rd[g]),
      .clr   (rdy & clear),
      .wdata (wdata[g]),
      .head  (head[g]),
      .cnt   (cnt[g])
    );
  end

  // last_src=1 means LSB went last, so ALU takes the next tie.
  assign gnt[0] = nonempty[0] & (~nonempty[1] | last_src);
  assign gnt[1] = nonempty[1] & ~gnt[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_en       <= 1'b0;
      cdb_rob_id   <= '0;
      cdb_val      <= '0;
      cdb_pc       <= '0;
      cdb_br       <= 1'b0;
      cdb_src      <= 1'b0;
      last_src     <= 1'b1;
      ovf_err      <= 1'b0;
      conflict_cnt <= '0;
    end else if (rdy) begin
      if (&nonempty && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
      if (clear) begin
        cdb_en   <= 1'b0;
        last_src <= 1'b1;
      end else begin
        if (|(en_in & full)) ovf_err <= 1'b1;
        cdb_en <= |gnt;
        if (|gnt) begin
          {cdb_rob_id, cdb_val, cdb_pc, cdb_br} <= head[gnt[1]];
          cdb_src  <= gnt[1];
          last_src <= gnt[1];
        end
      end
    end
  end

  assign bus.alu_full   = full[0];
  assign bus.lsb_full   = full[1];
  assign bus.cdb_en     = cdb_en;
  assign bus.cdb_rob_id = cdb_rob_id;
  assign bus.cdb_val    = cdb_val;
  assign bus.cdb_pc     = cdb_pc;
  assign bus.cdb_br     = cdb_br;
  assign bus.cdb_src    = cdb_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table for the steady-state bus
// behaviour, hand sequences for overflow, clear, rdy stall and async reset.
module tb_cdb_arbiter;
  logic        clk = 1'b0, rst = 1'b0, rdy = 1'b0, clear = 1'b0;
  logic        ovf_err;
  logic [15:0] conflict_cnt;
  int          n_pass = 0, n_tot = 0;

  cdb_arbiter_if #(.ROB_ID_W(4)) bus ();

  cdb_arbiter #(.FIFO_DEPTH(2), .ROB_ID_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .clear        (clear),
    .bus          (bus),
    .ovf_err      (ovf_err),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ae;  logic [3:0] aid; logic [31:0] aval, apc; logic abr;
    logic        le;  logic [3:0] lid; logic [31:0] lval;
    logic        en;  logic [3:0] id;  logic [31:0] val, pc;  logic br, src;
    logic [15:0] cc;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ae, input logic [3:0] aid, input logic [31:0] aval,
                       input logic [31:0] apc, input logic abr,
                       input logic le, input logic [3:0] lid, input logic [31:0] lval);
    bus.alu_en = ae; bus.alu_rob_id = aid; bus.alu_val = aval; bus.alu_pc = apc; bus.alu_br = abr;
    bus.lsb_en = le; bus.lsb_rob_id = lid; bus.lsb_val = lval;
  endtask

  // Short form: payload derived from the id.
  task automatic drv(input logic ae, input logic [3:0] aid, input logic le, input logic [3:0] lid);
    drive(ae, aid, 32'hA000 | 32'(aid), 32'h400 | 32'(aid), aid[0], le, lid, 32'hB000 | 32'(lid));
  endtask

  task automatic exp_cdb(input string nm, input logic en, input logic [3:0] id, input logic src);
    chk({nm, ".en"}, 64'(bus.cdb_en), 64'(en));
    if (en) begin
      chk({nm, ".id"}, 64'(bus.cdb_rob_id), 64'(id));
      chk({nm, ".src"}, 64'(bus.cdb_src), 64'(src));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drv(0, 0, 0, 0);
    clear = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1, 1, 32'h11,   32'h0,   0, 1, 2, 32'h22, 0, 0, 32'h0,    32'h0,   0, 0, 0};
    tbl[1]  = '{0, 0, 32'h0,    32'h0,   0, 0, 0, 32'h0,  1, 1, 32'h11,   32'h0,   0, 0, 1};
    tbl[2]  = '{0, 0, 32'h0,    32'h0,   0, 0, 0, 32'h0,  1, 2, 32'h22,   32'h0,   0, 1, 1};
    tbl[3]  = '{0, 0, 32'h0,    32'h0,   0, 0, 0, 32'h0,  0, 2, 32'h22,   32'h0,   0, 1, 1};
    tbl[4]  = '{1, 3, 32'h1234, 32'h100, 1, 0, 0, 32'h0,  0, 2, 32'h22,   32'h0,   0, 1, 1};
    tbl[5]  = '{0, 0, 32'h0,    32'h0,   0, 0, 0, 32'h0,  1, 3, 32'h1234, 32'h100, 1, 0, 1};
    tbl[6]  = '{0, 0, 32'h0,    32'h0,   0, 0, 0, 32'h0,  0, 3, 32'h1234, 32'h100, 1, 0, 1};
    tbl[7]  = '{0, 0, 32'h0,    32'h0,   0, 1, 5, 32'h55, 0, 3, 32'h1234, 32'h100, 1, 0, 1};
    tbl[8]  = '{1, 6, 32'h66,   32'h200, 0, 0, 0, 32'h0,  1, 5, 32'h55,   32'h0,   0, 1, 1};
    tbl[9]  = '{0, 0, 32'h0,    32'h0,   0, 0, 0, 32'h0,  1, 6, 32'h66,   32'h200, 0, 0, 1};
    tbl[10] = '{1, 7, 32'h77,   32'h0,   0, 1, 8, 32'h88, 0, 6, 32'h66,   32'h200, 0, 0, 1};
    tbl[11] = '{0, 0, 32'h0,    32'h0,   0, 0, 0, 32'h0,  1, 8, 32'h88,   32'h0,   0, 1, 2};
    tbl[12] = '{0, 0, 32'h0,    32'h0,   0, 0, 0, 32'h0,  1, 7, 32'h77,   32'h0,   0, 0, 2};
    tbl[13] = '{0, 0, 32'h0,    32'h0,   0, 0, 0, 32'h0,  0, 7, 32'h77,   32'h0,   0, 0, 2};

    // Reset state
    do_reset();
    rst = 1'b0;
    tick();
    chk("rst.cdb_en",  64'(bus.cdb_en), 0);
    chk("rst.cdb_id",  64'(bus.cdb_rob_id), 0);
    chk("rst.cdb_val", 64'(bus.cdb_val), 0);
    chk("rst.alu_full", 64'(bus.alu_full), 0);
    chk("rst.lsb_full", 64'(bus.lsb_full), 0);
    chk("rst.ovf", 64'(ovf_err), 0);
    chk("rst.cc", 64'(conflict_cnt), 0);
    rst = 1'b1;
    rdy = 1'b1;

    // Tie, single ALU, LSB pc/br zeroing, round robin
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].ae, tbl[i].aid, tbl[i].aval, tbl[i].apc, tbl[i].abr,
            tbl[i].le, tbl[i].lid, tbl[i].lval);
      tick();
      chk($sformatf("vec%0d.en", i),  64'(bus.cdb_en), 64'(tbl[i].en));
      chk($sformatf("vec%0d.id", i),  64'(bus.cdb_rob_id), 64'(tbl[i].id));
      chk($sformatf("vec%0d.val", i), 64'(bus.cdb_val), 64'(tbl[i].val));
      chk($sformatf("vec%0d.pc", i),  64'(bus.cdb_pc), 64'(tbl[i].pc));
      chk($sformatf("vec%0d.br", i),  64'(bus.cdb_br), 64'(tbl[i].br));
      chk($sformatf("vec%0d.src", i), 64'(bus.cdb_src), 64'(tbl[i].src));
      chk($sformatf("vec%0d.cc", i),  64'(conflict_cnt), 64'(tbl[i].cc));
      chk($sformatf("vec%0d.full", i), 64'({bus.alu_full, bus.lsb_full}), 0);
    end

    // rdy stall: state frozen, inputs and clear ignored
    do_reset();
    drv(1, 1, 1, 2);  tick(); exp_cdb("rdy.e0", 0, 0, 0);
    drv(1, 3, 0, 0);  tick(); exp_cdb("rdy.e1", 1, 1, 0);
    rdy = 1'b0; clear = 1'b1;
    drv(1, 9, 1, 10);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_cdb($sformatf("rdy.stall%0d", i), 1, 1, 0);
      chk($sformatf("rdy.stall%0d.cc", i), 64'(conflict_cnt), 1);
      chk($sformatf("rdy.stall%0d.full", i), 64'({bus.alu_full, bus.lsb_full}), 0);
    end
    rdy = 1'b1; clear = 1'b0;
    drv(0, 0, 0, 0);
    tick(); exp_cdb("rdy.r0", 1, 2, 1);
    chk("rdy.cc", 64'(conflict_cnt), 2);
    tick(); exp_cdb("rdy.r1", 1, 3, 0);
    tick(); exp_cdb("rdy.r2", 0, 0, 0);
    chk("rdy.ovf", 64'(ovf_err), 0);

    // Async reset mid-transfer
    drv(1, 5, 0, 0); tick();
    drv(1, 6, 0, 0); tick(); exp_cdb("arst.pre", 1, 5, 0);
    drv(0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst.en", 64'(bus.cdb_en), 0);
    chk("arst.cc", 64'(conflict_cnt), 0);
    tick();
    rst = 1'b1;
    tick(); exp_cdb("arst.p0", 0, 0, 0);
    tick(); exp_cdb("arst.p1", 0, 0, 0);
    chk("arst.full", 64'({bus.alu_full, bus.lsb_full}), 0);

    // ALU overflow under contention
    drv(1, 9, 1, 4); tick(); exp_cdb("ovf.e0", 0, 0, 0);
    drv(1, 1, 1, 5); tick(); exp_cdb("ovf.e1", 1, 9, 0);
    chk("ovf.e1.lsb_full", 64'(bus.lsb_full), 1);
    chk("ovf.e1.alu_full", 64'(bus.alu_full), 0);
    drv(1, 2, 0, 0); tick(); exp_cdb("ovf.e2", 1, 4, 1);
    chk("ovf.e2.alu_full", 64'(bus.alu_full), 1);
    chk("ovf.e2.ovf", 64'(ovf_err), 0);
    drv(1, 3, 0, 0); tick(); exp_cdb("ovf.e3", 1, 1, 0);
    chk("ovf.e3.ovf", 64'(ovf_err), 1);
    chk("ovf.e3.alu_full", 64'(bus.alu_full), 0);
    drv(0, 0, 0, 0); tick(); exp_cdb("ovf.e4", 1, 5, 1);
    tick(); exp_cdb("ovf.e5", 1, 2, 0);
    chk("ovf.e5.val", 64'(bus.cdb_val), 64'h0000A002);
    tick(); exp_cdb("ovf.e6", 0, 0, 0);
    chk("ovf.cc", 64'(conflict_cnt), 4);

    // Clear flush with buffered entries
    drv(1, 1, 1, 4); tick(); exp_cdb("clr.e0", 0, 0, 0);
    drv(1, 2, 1, 5); tick(); exp_cdb("clr.e1", 1, 4, 1);
    chk("clr.e1.alu_full", 64'(bus.alu_full), 1);
    drv(1, 3, 1, 6); clear = 1'b1; tick(); exp_cdb("clr.e2", 0, 0, 0);
    chk("clr.full", 64'({bus.alu_full, bus.lsb_full}), 0);
    chk("clr.ovf", 64'(ovf_err), 1);
    clear = 1'b0; drv(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_cdb($sformatf("clr.idle%0d", i), 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
